// File: rtl/asmd_multiplier_param.sv
// Parametrised shift-add multiplier: ASMD controller plus datapath, signed/unsigned at run time.
// Optional macro ASMD_EARLY_TERM_EN finishes as soon as the remaining multiplier bits are all zero.
module asmd_multiplier_param #(
  parameter int word_length = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic [word_length-1:0]     word0,
  input  logic [word_length-1:0]     word1,
  output logic [2*word_length-1:0]   product,
  output logic                       ready,
  output logic                       done
);

  localparam int W  = word_length;
  localparam int CW = $clog2(W + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [2*W:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [2*W-1:0]  product_q, product_d;
  logic            done_q, done_d;

  logic [2*W:0]    sum;
  logic [2*W:0]    step;
  logic [2*W-1:0]  mag;
  logic            last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    done_d    = 1'b0;

    // Multiplicand enters the upper half; the extra top bit absorbs the carry.
    sum  = acc_q + (mplier_q[0] ? {1'b0, mcand_q, {W{1'b0}}} : '0);
    step = sum >> 1;
    mag  = step[2*W-1:0];
    last = (cnt_q == CW'(1));
`ifdef ASMD_EARLY_TERM_EN
    if ((mplier_q >> 1) == '0) begin
      last = 1'b1;
      mag  = step[2*W-1:0] >> (cnt_q - CW'(1));
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = (signed_mode && word0[W-1]) ? -word0 : word0;
          mplier_d = (signed_mode && word1[W-1]) ? -word1 : word1;
          neg_d    = signed_mode & (word0[W-1] ^ word1[W-1]);
          cnt_d    = CW'(W);
          acc_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (last) begin
          product_d = neg_q ? -mag : mag;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign product = product_q;
  assign ready   = (state_q == S_IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_asmd_multiplier_param.sv
// Directed plus randomized bench for asmd_multiplier_param (8-bit and 4-bit instances).
module tb_asmd_multiplier_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        st8, sm8, r8, d8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        st4, sm4, r4, d4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  int checks = 0;
  int errors = 0;

  asmd_multiplier_param #(.word_length(8)) dut8 (
    .clk(clk), .reset(reset), .start(st8), .signed_mode(sm8),
    .word0(a8), .word1(b8), .product(p8), .ready(r8), .done(d8));

  asmd_multiplier_param #(.word_length(4)) dut4 (
    .clk(clk), .reset(reset), .start(st4), .signed_mode(sm4),
    .word0(a4), .word1(b4), .product(p4), .ready(r4), .done(d4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input longint v, input int w);
    return v[w-1] ? v - (longint'(1) << w) : v;
  endfunction

  function automatic logic [63:0] ref_prod(input longint a, input longint b, input bit sm, input int w);
    longint p;
    p = sm ? sx(a, w) * sx(b, w) : a * b;
    return p & ((longint'(1) << (2 * w)) - 1);
  endfunction

  // Cycles from accept edge to product valid.
  function automatic int ref_lat(input longint b, input bit sm, input int w);
    longint m;
    int     l;
    m = (sm && sx(b, w) < 0) ? -sx(b, w) : b;
    l = 1;
    for (int i = 0; i < w; i++) if (m[i]) l = i + 1;
`ifdef ASMD_EARLY_TERM_EN
    return l;
`else
    return (l > 0) ? w : w;
`endif
  endfunction

  function automatic logic [15:0] prod(input int s);
    return s != 0 ? {8'h00, p4} : p8;
  endfunction
  function automatic logic rdy(input int s);
    return s != 0 ? r4 : r8;
  endfunction
  function automatic logic dn(input int s);
    return s != 0 ? d4 : d8;
  endfunction

  task automatic drive(input int s, input logic [7:0] a, input logic [7:0] b, input logic sm, input logic st);
    if (s != 0) begin
      st4 = st; sm4 = sm; a4 = a[3:0]; b4 = b[3:0];
    end else begin
      st8 = st; sm8 = sm; a8 = a; b8 = b;
    end
  endtask

  task automatic scramble(input int s);
    drive(s, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic run_op(input int s, input logic [7:0] a_in, input logic [7:0] b_in, input logic sm,
                        input bit busy, input bit b2b, input string tag);
    int          w;
    longint      a, b;
    logic [63:0] exp;
    int          lat;
    int          seen;
    logic [15:0] prev;
    w    = (s != 0) ? 4 : 8;
    a    = (s != 0) ? longint'(a_in[3:0]) : longint'(a_in);
    b    = (s != 0) ? longint'(b_in[3:0]) : longint'(b_in);
    exp  = ref_prod(a, b, sm, w);
    lat  = ref_lat(b, sm, w);
    seen = 0;
    prev = prod(s);
    drive(s, a_in, b_in, sm, 1'b1);
    @(posedge clk); #1;
    scramble(s);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (dn(s)) begin
        seen = i;
        break;
      end
      chk({tag, "_ready_low"}, 64'(rdy(s)), 64'd0);
      chk({tag, "_hold"}, 64'(prod(s)), 64'(prev));
      if (busy && i == 2) drive(s, ~a_in, ~b_in, ~sm, 1'b1);
      if (busy && i == 3) scramble(s);
    end
    chk({tag, "_latency"}, 64'(seen), 64'(lat));
    chk({tag, "_product"}, 64'(prod(s)), exp);
    chk({tag, "_ready_done"}, 64'(rdy(s)), 64'd1);
    if (!b2b) begin
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, 64'(dn(s)), 64'd0);
      chk({tag, "_product_stable"}, 64'(prod(s)), exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 8'd0, 8'd0, 1'b0, 1'b0);
    drive(1, 8'd0, 8'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_product", 64'(p8), 64'd0);
    chk("rst_ready", 64'(r8), 64'd1);
    chk("rst_done", 64'(d8), 64'd0);
    chk("rst4_product", 64'(p4), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(0, 8'd255, 8'd255, 1'b0, 1'b0, 1'b0, "u255x255");
    run_op(0, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0, "s_m128sq");
    run_op(0, 8'hFD, 8'd5, 1'b1, 1'b0, 1'b0, "s_m3x5");
    run_op(0, 8'd0, 8'hF9, 1'b1, 1'b0, 1'b0, "s_0xm7");
    run_op(0, 8'd9, 8'd1, 1'b0, 1'b0, 1'b0, "u9x1");
    run_op(0, 8'd12, 8'd10, 1'b0, 1'b1, 1'b1, "busy12x10");
    run_op(0, 8'd33, 8'd77, 1'b0, 1'b0, 1'b0, "b2b33x77");

    // Reset in the middle of 200x3.
    drive(0, 8'd200, 8'd3, 1'b0, 1'b1);
    @(posedge clk); #1;
    scramble(0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", 64'(r8), 64'd1);
    chk("midrst_done", 64'(d8), 64'd0);
    chk("midrst_product", 64'(p8), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_done", 64'(d8), 64'd0);
    end
    run_op(0, 8'd7, 8'd6, 1'b0, 1'b0, 1'b0, "u7x6");

    run_op(1, 8'd15, 8'd15, 1'b0, 1'b0, 1'b0, "w4_15x15");
    run_op(1, 8'd8, 8'd8, 1'b1, 1'b0, 1'b0, "w4_m8sq");

    for (int n = 0; n < 24; n++) begin
      run_op(n % 2, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/asmd_multiplier_param.md
Name: asmd_multiplier_param

Overview:
- Parametrised sequential shift-add multiplier built as an ASMD datapath/controller pair; next generation of the team's fixed-function ASMD multiplier.
- Adds configurable operand width, run-time signed/unsigned mode, a one-cycle done strobe, and defined start-while-busy and mid-operation reset behaviour.
- Sits beside the arithmetic lab datapaths as a low-area multiplier: one partial product per clock, start/ready handshake to the controlling FSM.

Parameters:
- word_length, 8, operand width in bits; must be >= 2; product is 2*word_length bits.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  request; accepted only on an edge where ready=1.
- signed_mode  input  1  sampled with start: 1 = two's-complement operands, 0 = unsigned.
- word0  input  word_length  multiplicand; sampled at accept.
- word1  input  word_length  multiplier; sampled at accept.
- product  output  2*word_length  result register; holds the last completed result.
- ready  output  1  1 = idle and able to accept start.
- done  output  1  one-cycle pulse marking that product was just updated.

Behaviour:
- Reset (edge with reset=1): state=S_IDLE, product=0, ready=1, done=0, internal registers cleared. Reset overrides start and any in-flight operation; the aborted result is discarded and product still reads 0.
- States: S_IDLE, S_RUN.
- S_IDLE: ready=1. On an edge with start=1, latch operands and mode, set bit counter=word_length, clear the accumulator, go to S_RUN. ready falls after that edge (accept edge k).
- Signed handling at accept: if signed_mode=1, store |word0| and |word1| as word_length-bit unsigned magnitudes; -2^(word_length-1) maps to 2^(word_length-1), which fits. Store neg = sign0 XOR sign1. If signed_mode=0, store operands as-is with neg=0.
- S_RUN, one step per edge:
  - if the multiplier LSB is 1, add the multiplicand (aligned to the upper half) into the 2*word_length+1-bit accumulator;
  - shift the accumulator and multiplier right by 1;
  - decrement the counter.
- Completion: on the edge where the counter reaches 0 (edge k+word_length):
  - product = neg ? two's-complement negation of the magnitude : magnitude;
  - done=1 for exactly the following cycle;
  - ready=1 and state returns to S_IDLE.
- Latency: word_length cycles from the accept edge to product valid. Throughput: a new start is accepted on the edge after done rises (ready is already 1 during the done cycle), giving back-to-back operation at word_length+1 edges per result.
- start while ready=0: ignored, with no effect on the operation in flight. start held high continuously re-triggers on each idle edge.
- product is unchanged during S_RUN and changes only at completion or reset.
- Width rules: unsigned results are exact for all operand pairs. Signed results are exact, including (-2^(W-1))^2 = 2^(2W-2), which is positive and representable. Zero results are never negative zero (negating 0 gives 0).
- Operand or mode changes after the accept edge do not affect the result.

Optional Feature:
- Macro: ASMD_EARLY_TERM_EN.
- Defined: in S_RUN, if the remaining multiplier bits are all zero after a step, the result is final. Completion occurs on that same edge, with product adjusted by the remaining shift so the value is identical. Latency = max(1, index of the highest set bit of |word1| + 1) cycles; word1=0 completes at k+1.
- Not defined: fixed latency of word_length cycles for all operands; no early-exit logic is synthesised.

Test Plan:
- word_length=8, unsigned, word0=255, word1=255, start at edge k -> ready=0 for edges k+1..k+7; at edge k+8 product=0xFE01 (65025), done=1 for one cycle, ready=1.
- Signed: -128 x -128 -> product=0x4000 (16384); -3 x 5 -> product=0xFFF1 (-15); 0 x -7 -> product=0x0000; each with done at k+8.
- Busy start: start pulsed at k+3 with different operands during 12x10 -> product=120 at k+8, no second done; a new start at the done cycle is accepted and its result arrives 8 cycles later.
- Reset mid-operation: reset=1 at k+4 of 200x3 -> after that edge ready=1, done=0, product=0, and no done appears at k+8; a subsequent 7x6 yields 42.
- Early term: word1=1, word0=9. With ASMD_EARLY_TERM_EN: product=9 and done at k+1. Without: done at k+8. Also word_length=4 unsigned 15x15 -> 0xE1 at k+4.
